// File: rtl/fp16_pkg.sv
// Shared definitions for the 16-bit float format (sign, 5-bit two's-complement
// exponent with no bias, 10-bit fraction with hidden 1) used by fmul and fadd.
package fp16_pkg;

  localparam int EXP_W   = 5;
  localparam int FRAC_W  = 10;
  localparam int MANT_W  = FRAC_W + 1;
  localparam int PROD_W  = 2 * MANT_W;
  localparam int EXP_MAX = 15;
  localparam int EXP_MIN = -15;

  localparam logic [EXP_W-1:0] ZERO_EXP = 5'b10000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    NORM = 2'd2,
    PACK = 2'd3
  } fmul_state_t;

  // Zero is the reserved exponent with an all-zero fraction, either sign.
  function automatic logic is_zero(input logic [15:0] v);
    return (v[14:10] == ZERO_EXP) && (v[9:0] == '0);
  endfunction

endpackage

// File: rtl/mant_mul11.sv
// Iterative 11x11 unsigned shift-add multiplier: one multiplier bit per cycle,
// product valid once busy falls. start reloads operands from any state.
module mant_mul11
  import fp16_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [MANT_W-1:0] a,
  input  logic [MANT_W-1:0] b,
  output logic              busy,
  output logic [PROD_W-1:0] product
);

  logic [PROD_W-1:0] mcand_reg, mcand_next;
  logic [MANT_W-1:0] mplier_reg, mplier_next;
  logic [PROD_W-1:0] acc_reg, acc_next;
  logic [3:0]        cnt_reg, cnt_next;
  logic              busy_reg, busy_next;

  always_comb begin
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    busy_next   = busy_reg;
    if (start) begin
      mcand_next  = {{MANT_W{1'b0}}, a};
      mplier_next = b;
      acc_next    = '0;
      cnt_next    = '0;
      busy_next   = 1'b1;
    end else if (busy_reg) begin
      // Multiplicand shifts left while the multiplier shifts right,
      // so bit 0 of the multiplier always selects the current row.
      if (mplier_reg[0]) acc_next = acc_reg + mcand_reg;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg + 4'd1;
      if (cnt_reg == 4'(MANT_W - 1)) busy_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      busy_reg   <= 1'b0;
    end else begin
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      busy_reg   <= busy_next;
    end
  end

  assign busy    = busy_reg;
  assign product = acc_reg;

endmodule

// File: rtl/fmul.sv
// Sequential 16-bit float multiplier: IDLE -> MUL (11 cycles) -> NORM -> PACK.
// Define FMUL_ROUND_EN for round-to-nearest-even; otherwise the fraction truncates.
module fmul
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        st,
  input  logic [15:0] sig1,
  input  logic [15:0] sig2,
  output logic [15:0] sigout,
  output logic        done,
  output logic        ovf,
  output logic        unf
);

  fmul_state_t        state_reg, state_next;
  logic [3:0]         cnt_reg, cnt_next;
  logic               s_reg, s_next;
  logic               zero_reg, zero_next;
  logic signed [6:0]  e1_reg, e1_next;
  logic signed [6:0]  e2_reg, e2_next;
  logic signed [6:0]  exp_reg, exp_next;
  // {hidden, fraction[9:0], guard, sticky} after normalization
  logic [12:0]        mant_reg, mant_next;
  logic [15:0]        sigout_reg, sigout_next;
  logic               done_reg, done_next;
  logic               ovf_reg, ovf_next;
  logic               unf_reg, unf_next;

  logic               op_zero;
  logic               mul_start;
  logic               mul_busy;
  logic [PROD_W-1:0]  product;
  logic [9:0]         pk_frac;
  logic signed [6:0]  pk_exp;

  assign op_zero   = is_zero(sig1) || is_zero(sig2);
  assign mul_start = (state_reg == IDLE) && st && !op_zero;

  mant_mul11 u_mant_mul11 (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       ({1'b1, sig1[9:0]}),
    .b       ({1'b1, sig2[9:0]}),
    .busy    (mul_busy),
    .product (product)
  );

`ifdef FMUL_ROUND_EN
  logic        rnd_up;
  logic [11:0] rnd_sum;

  always_comb begin
    rnd_up  = mant_reg[1] & (mant_reg[0] | mant_reg[2]);
    rnd_sum = {1'b0, mant_reg[12:2]} + {11'b0, rnd_up};
    // A carry out of the mantissa means 2.0: renormalize before range checks.
    if (rnd_sum[11]) begin
      pk_frac = rnd_sum[10:1];
      pk_exp  = exp_reg + 7'sd1;
    end else begin
      pk_frac = rnd_sum[9:0];
      pk_exp  = exp_reg;
    end
  end
`else
  logic unused_round_bits;
  assign unused_round_bits = ^{mant_reg[12], mant_reg[1:0]};
  assign pk_frac = mant_reg[11:2];
  assign pk_exp  = exp_reg;
`endif

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    s_next      = s_reg;
    zero_next   = zero_reg;
    e1_next     = e1_reg;
    e2_next     = e2_reg;
    exp_next    = exp_reg;
    mant_next   = mant_reg;
    sigout_next = sigout_reg;
    done_next   = done_reg;
    ovf_next    = ovf_reg;
    unf_next    = unf_reg;

    case (state_reg)
      IDLE: begin
        if (st) begin
          s_next     = sig1[15] ^ sig2[15];
          e1_next    = {{2{sig1[14]}}, sig1[14:10]};
          e2_next    = {{2{sig2[14]}}, sig2[14:10]};
          zero_next  = op_zero;
          cnt_next   = '0;
          done_next  = 1'b0;
          ovf_next   = 1'b0;
          unf_next   = 1'b0;
          state_next = op_zero ? PACK : MUL;
        end
      end

      MUL: begin
        if (mul_busy) cnt_next = cnt_reg + 4'd1;
        if (cnt_reg == 4'(MANT_W - 1) || !mul_busy) state_next = NORM;
      end

      NORM: begin
        // Product of two [1,2) mantissas lies in [1,4): at most one right shift.
        if (product[PROD_W-1]) begin
          mant_next = {product[21:11], product[10], |product[9:0]};
          exp_next  = e1_reg + e2_reg + 7'sd1;
        end else begin
          mant_next = {product[20:10], product[9], |product[8:0]};
          exp_next  = e1_reg + e2_reg;
        end
        state_next = PACK;
      end

      PACK: begin
        done_next  = 1'b1;
        state_next = IDLE;
        if (zero_reg) begin
          sigout_next = {s_reg, ZERO_EXP, {FRAC_W{1'b0}}};
        end else if (pk_exp > $signed(7'(EXP_MAX))) begin
          ovf_next    = 1'b1;
          sigout_next = {s_reg, 5'(EXP_MAX), {FRAC_W{1'b1}}};
        end else if (pk_exp < $signed(7'(EXP_MIN))) begin
          unf_next    = 1'b1;
          sigout_next = {s_reg, ZERO_EXP, {FRAC_W{1'b0}}};
        end else begin
          sigout_next = {s_reg, pk_exp[4:0], pk_frac};
        end
      end

      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      s_reg      <= 1'b0;
      zero_reg   <= 1'b0;
      e1_reg     <= '0;
      e2_reg     <= '0;
      exp_reg    <= '0;
      mant_reg   <= '0;
      sigout_reg <= '0;
      done_reg   <= 1'b0;
      ovf_reg    <= 1'b0;
      unf_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      s_reg      <= s_next;
      zero_reg   <= zero_next;
      e1_reg     <= e1_next;
      e2_reg     <= e2_next;
      exp_reg    <= exp_next;
      mant_reg   <= mant_next;
      sigout_reg <= sigout_next;
      done_reg   <= done_next;
      ovf_reg    <= ovf_next;
      unf_reg    <= unf_next;
    end
  end

  assign sigout = sigout_reg;
  assign done   = done_reg;
  assign ovf    = ovf_reg;
  assign unf    = unf_reg;

endmodule

// File: tb/tb_fmul.sv
// Directed testbench for fmul: hand-computed products, flags, latency,
// zero shortcut, rounding option (FMUL_ROUND_EN) and reset behaviour.
module tb_fmul;

  logic        clk;
  logic        reset;
  logic        st;
  logic [15:0] sig1;
  logic [15:0] sig2;
  logic [15:0] sigout;
  logic        done;
  logic        ovf;
  logic        unf;

  int tests = 0;
  int fails = 0;

  fmul dut (
    .clk    (clk),
    .reset  (reset),
    .st     (st),
    .sig1   (sig1),
    .sig2   (sig2),
    .sigout (sigout),
    .done   (done),
    .ovf    (ovf),
    .unf    (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands and hold st across exactly one rising edge (the capture edge).
  task automatic start_op(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    sig1 = a;
    sig2 = b;
    st   = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
  endtask

  // Edges counted after the capture edge until done is seen (bounded).
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    st    = 1'b1;
    sig1  = 16'h0200;
    sig2  = 16'h0200;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (sigout !== 16'h0000) begin fails++; $display("FAIL reset_sigout: got %h expected 0000", sigout); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
    tests++; if (unf !== 1'b0) begin fails++; $display("FAIL reset_unf: got %b expected 0", unf); end
    @(negedge clk);
    st    = 1'b0;
    reset = 1'b0;
    $display("[TB] reset: sigout=%h done=%b ovf=%b unf=%b", sigout, done, ovf, unf);
  endtask

  task automatic test_basic;
    int n;
    start_op(16'h0200, 16'h0200);
    wait_done(n);
    $display("[TB] 0200 x 0200 -> %h ovf=%b unf=%b latency=%0d", sigout, ovf, unf, n);
    tests++; if (n !== 13) begin fails++; $display("FAIL basic_latency: got %0d expected 13", n); end
    tests++; if (sigout !== 16'h0480) begin fails++; $display("FAIL basic_sigout: got %h expected 0480", sigout); end
    tests++; if (ovf !== 1'b0 || unf !== 1'b0) begin fails++; $display("FAIL basic_flags: got ovf=%b unf=%b expected 0 0", ovf, unf); end
  endtask

  task automatic test_done_hold;
    repeat (6) @(posedge clk);
    #1;
    $display("[TB] hold: sigout=%h done=%b", sigout, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL hold_done: got %b expected 1", done); end
    tests++; if (sigout !== 16'h0480) begin fails++; $display("FAIL hold_sigout: got %h expected 0480", sigout); end
  endtask

  task automatic test_sign;
    int n;
    start_op(16'h0400, 16'h8400);
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL sign_done_clear: got %b expected 0", done); end
    wait_done(n);
    $display("[TB] 0400 x 8400 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'h8800) begin fails++; $display("FAIL sign_sigout: got %h expected 8800", sigout); end
    tests++; if (n !== 13) begin fails++; $display("FAIL sign_latency: got %0d expected 13", n); end
  endtask

  task automatic test_overflow;
    int n;
    start_op(16'h3C00, 16'h0400);
    wait_done(n);
    $display("[TB] 3C00 x 0400 -> %h ovf=%b unf=%b done=%b", sigout, ovf, unf, done);
    tests++; if (done !== 1'b1) begin fails++; $display("FAIL ovf_done: got %b expected 1", done); end
    tests++; if (ovf !== 1'b1 || unf !== 1'b0) begin fails++; $display("FAIL ovf_flags: got ovf=%b unf=%b expected 1 0", ovf, unf); end
    tests++; if (sigout !== 16'h3FFF) begin fails++; $display("FAIL ovf_sigout: got %h expected 3FFF", sigout); end
  endtask

  task automatic test_underflow;
    int n;
    start_op(16'h4400, 16'h7C00);
    tests++; if (ovf !== 1'b0) begin fails++; $display("FAIL unf_ovf_clear: got %b expected 0", ovf); end
    wait_done(n);
    $display("[TB] 4400 x 7C00 -> %h ovf=%b unf=%b", sigout, ovf, unf);
    tests++; if (unf !== 1'b1 || ovf !== 1'b0) begin fails++; $display("FAIL unf_flags: got ovf=%b unf=%b expected 0 1", ovf, unf); end
    tests++; if (sigout !== 16'h4000) begin fails++; $display("FAIL unf_sigout: got %h expected 4000", sigout); end
  endtask

  task automatic test_zero;
    int n;
    start_op(16'h4000, 16'h0200);
    wait_done(n);
    $display("[TB] 4000 x 0200 -> %h latency=%0d", sigout, n);
    // Capture edge plus one more edge.
    tests++; if (n !== 1) begin fails++; $display("FAIL zero_latency: got %0d expected 1", n); end
    tests++; if (sigout !== 16'h4000) begin fails++; $display("FAIL zero_sigout: got %h expected 4000", sigout); end
    tests++; if (unf !== 1'b0) begin fails++; $display("FAIL zero_unf: got %b expected 0", unf); end
    start_op(16'hC000, 16'h0200);
    wait_done(n);
    $display("[TB] C000 x 0200 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'hC000) begin fails++; $display("FAIL negzero_sigout: got %h expected C000", sigout); end
  endtask

  task automatic test_round;
    int n;
    logic [15:0] exp_val;
`ifdef FMUL_ROUND_EN
    exp_val = 16'h0203;
`else
    exp_val = 16'h0202;
`endif
    start_op(16'h0001, 16'h0201);
    wait_done(n);
    $display("[TB] 0001 x 0201 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== exp_val) begin fails++; $display("FAIL round_sigout: got %h expected %h", sigout, exp_val); end
    tests++; if (n !== 13) begin fails++; $display("FAIL round_latency: got %0d expected 13", n); end
  endtask

  task automatic test_reset_mid_op;
    int n;
    int seen;
    // sigout holds a nonzero value from the previous operation here.
    start_op(16'h0200, 16'h0200);
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    $display("[TB] reset mid-MUL: sigout=%h done=%b ovf=%b unf=%b", sigout, done, ovf, unf);
    tests++; if (sigout !== 16'h0000) begin fails++; $display("FAIL midreset_sigout: got %h expected 0000", sigout); end
    tests++; if (done !== 1'b0 || ovf !== 1'b0 || unf !== 1'b0) begin fails++; $display("FAIL midreset_flags: got done=%b ovf=%b unf=%b expected 0 0 0", done, ovf, unf); end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    repeat (25) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) seen = 1;
    end
    tests++; if (seen !== 0) begin fails++; $display("FAIL midreset_no_done: got %0d expected 0", seen); end
    start_op(16'h0400, 16'h8400);
    wait_done(n);
    $display("[TB] resume 0400 x 8400 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'h8800 || n !== 13) begin fails++; $display("FAIL resume: got %h/%0d expected 8800/13", sigout, n); end
  endtask

  task automatic test_st_ignored;
    int n;
    start_op(16'h0400, 16'h0400);
    repeat (4) @(posedge clk);
    @(negedge clk);
    sig1 = 16'h0200;
    sig2 = 16'h0200;
    st   = 1'b1;
    @(posedge clk);
    #1;
    st = 1'b0;
    wait_done(n);
    n = n + 5;
    $display("[TB] 0400 x 0400 with mid-MUL st -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'h0800) begin fails++; $display("FAIL stignore_sigout: got %h expected 0800", sigout); end
    tests++; if (n !== 13) begin fails++; $display("FAIL stignore_latency: got %0d expected 13", n); end
  endtask

  task automatic test_back_to_back;
    int n;
    start_op(16'h0200, 16'h0400);
    wait_done(n);
    $display("[TB] 0200 x 0400 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'h0600) begin fails++; $display("FAIL b2b_first: got %h expected 0600", sigout); end
    start_op(16'h8200, 16'h8200);
    wait_done(n);
    $display("[TB] 8200 x 8200 -> %h latency=%0d", sigout, n);
    tests++; if (sigout !== 16'h0480 || n !== 13) begin fails++; $display("FAIL b2b_second: got %h/%0d expected 0480/13", sigout, n); end
  endtask

  initial begin
    st   = 1'b0;
    sig1 = '0;
    sig2 = '0;
    test_reset();
    test_basic();
    test_done_hold();
    test_sign();
    test_overflow();
    test_underflow();
    test_zero();
    test_round();
    test_back_to_back();
    test_reset_mid_op();
    test_st_ignored();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
